// File: rtl/coord_bcd_converter_pkg.sv
// Shared constants and types for the coordinate BCD converter slice.
package coord_pkg;

  localparam int COORD_W    = 12;
  localparam int BCD_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [3:0] digit_t;

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/coord_bcd_converter_if.sv
// Request/result bundle between the display driver (master) and the BCD converter (slave).
interface coord_bcd_if
  import coord_pkg::*;
#(
  parameter int WIDTH  = COORD_W,
  parameter int DIGITS = BCD_DIGITS
);

  logic                  start;
  logic [WIDTH-1:0]      real_coord;
  logic                  sign;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, real_coord, sign,
    input  busy, done, bcd, neg, blank
  );

  modport slave (
    input  start, real_coord, sign,
    output busy, done, bcd, neg, blank
  );

endinterface

// File: rtl/coord_bcd_converter_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3
  import coord_pkg::*;
(
  input  digit_t din,
  output digit_t dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/coord_bcd_converter.sv
// Sequential double-dabble magnitude-to-BCD converter with start/busy/done handshake.
// Optional leading-zero blank mask enabled by defining COORD_BCD_LEADING_ZERO_BLANK_EN.
module coord_bcd_converter
  import coord_pkg::*;
#(
  parameter int WIDTH  = COORD_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input logic        clk,
  input logic        rst_n,
  coord_bcd_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  if (pow10(DIGITS) <= ((longint'(1) << WIDTH) - 1)) begin : g_width_check
    $error("coord_bcd_converter: DIGITS=%0d cannot hold a %0d-bit magnitude", DIGITS, WIDTH);
  end

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [WIDTH-1:0]    shift_q;
  logic [4*DIGITS-1:0] scratch_q;
  logic [4*DIGITS-1:0] adjusted;
  logic                sign_q;
  logic                nonzero_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic                neg_q;
  logic                done_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch_q[4*g +: 4]),
      .dout (adjusted[4*g +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Magnitude and sign are captured at start so later input changes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      sign_q    <= 1'b0;
      nonzero_q <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            shift_q   <= bus.real_coord;
            sign_q    <= bus.sign;
            nonzero_q <= (bus.real_coord != '0);
            scratch_q <= '0;
            cnt_q     <= '0;
          end
        end
        SHIFT: begin
          {scratch_q, shift_q} <= {adjusted, shift_q} << 1;
          cnt_q                <= cnt_q + CW'(1);
        end
        DONE: begin
          bcd_q  <= scratch_q;
          neg_q  <= sign_q & nonzero_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef COORD_BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_next;
  logic [DIGITS-1:0] blank_q;
  logic              upper_zero;

  // Digit 0 is never blanked so that a zero value still shows a single "0".
  always_comb begin
    blank_next = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero & (scratch_q[4*i +: 4] == 4'd0);
      blank_next[i] = upper_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               blank_q <= '0;
    else if (state_q == DONE) blank_q <= blank_next;
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = '0;
`endif

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.neg  = neg_q;

endmodule

// File: tb/tb_coord_bcd_converter.sv
// Randomized self-checking bench for coord_bcd_converter against a decimal-arithmetic model.
module tb_coord_bcd_converter;
  import coord_pkg::*;

  localparam int W = COORD_W;
  localparam int D = BCD_DIGITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  coord_bcd_if #(.WIDTH(W), .DIGITS(D)) bus ();

  coord_bcd_converter #(.WIDTH(W), .DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks      = 0;
  int failures    = 0;
  int doneSeen    = 0;
  int conversions = 0;
  logic [4*D-1:0] lastBcd = '0;

  // Count every done pulse independently of the stimulus flow.
  always @(posedge clk) begin
    #1;
    if (bus.done === 1'b1) doneSeen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [4*D-1:0] modelBcd(input int v);
    logic [4*D-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [D-1:0] modelBlank(input int v);
    logic [D-1:0] b;
    int p;
    b = '0;
`ifdef COORD_BCD_LEADING_ZERO_BLANK_EN
    p = 10;
    for (int i = 1; i < D; i++) begin
      b[i] = (v < p);
      p = p * 10;
    end
`else
    p = v;
`endif
    return b;
  endfunction

  // Entered and left at a falling edge; glitchAt/resetAt are cycle indices after the start edge (-1 = off).
  task automatic applyStimulus(input int v, input bit s, input int glitchAt, input int resetAt);
    int idx;
    int busyCycles;
    bit seenDone;
    bus.start      = 1'b1;
    bus.real_coord = W'(v);
    bus.sign       = s;
    @(posedge clk);
    @(negedge clk);
    bus.start      = 1'b0;
    bus.real_coord = W'($urandom);
    bus.sign       = 1'($urandom);
    idx        = 0;
    busyCycles = 0;
    seenDone   = 1'b0;
    while (idx < 40 && !seenDone) begin
      if (resetAt == idx) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy",  32'(bus.busy),  32'd0);
        checkOutput("rst_done",  32'(bus.done),  32'd0);
        checkOutput("rst_bcd",   32'(bus.bcd),   32'd0);
        checkOutput("rst_neg",   32'(bus.neg),   32'd0);
        checkOutput("rst_blank", 32'(bus.blank), 32'd0);
        lastBcd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("rst_no_done", 32'(doneSeen), 32'(conversions));
        checkOutput("rst_idle",    32'(bus.busy), 32'd0);
        return;
      end
      if (bus.done === 1'b1) begin
        seenDone = 1'b1;
      end else begin
        if (bus.busy === 1'b1) busyCycles++;
        if (glitchAt >= 0 && glitchAt == idx) begin
          bus.start      = 1'b1;
          bus.real_coord = W'(800);
        end else if (glitchAt >= 0 && glitchAt == idx - 1) begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        idx++;
      end
    end
    conversions++;
    lastBcd = modelBcd(v);
    checkOutput("latency",      32'(idx),        32'(W + 1));
    checkOutput("busy_cycles",  32'(busyCycles), 32'(W + 1));
    checkOutput("busy_at_done", 32'(bus.busy),   32'd0);
    checkOutput("bcd",          32'(bus.bcd),    32'(lastBcd));
    checkOutput("neg",          32'(bus.neg),    32'(s && v != 0));
    checkOutput("blank",        32'(bus.blank),  32'(modelBlank(v)));
    checkOutput("done_count",   32'(doneSeen),   32'(conversions));
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.real_coord = '0;
    bus.sign       = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy",  32'(bus.busy),  32'd0);
    checkOutput("reset_done",  32'(bus.done),  32'd0);
    checkOutput("reset_bcd",   32'(bus.bcd),   32'd0);
    checkOutput("reset_neg",   32'(bus.neg),   32'd0);
    checkOutput("reset_blank", 32'(bus.blank), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(4095, 1'b0, -1, -1);
    applyStimulus(0,    1'b1, -1, -1);
    applyStimulus(1234, 1'b1, -1, -1);
    applyStimulus(57,   1'b0,  4, -1);
    applyStimulus(800,  1'b0, -1, -1);
    applyStimulus(321,  1'b1, -1,  5);
    applyStimulus(100,  1'b0, -1, -1);
    applyStimulus(7,    1'b1, -1, -1);
    applyStimulus(999,  1'b1, -1, -1);
    repeat (3) @(negedge clk);
    for (int n = 0; n < 25; n++) begin
      applyStimulus(int'($urandom_range(0, (1 << W) - 1)), 1'($urandom), -1, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (6) @(negedge clk);
    checkOutput("final_done_count", 32'(doneSeen), 32'(conversions));
    checkOutput("final_bcd_hold",   32'(bus.bcd),  32'(lastBcd));
    checkOutput("final_idle",       32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coord_bcd_converter.md
Name: coord_bcd_converter

Overview:
- Sits directly downstream of the coordinate sign-deduction stage.
- Takes a 12-bit unsigned magnitude and a sign flag, and converts the magnitude to 4 BCD digits using sequential double-dabble (shift-add-3), one bit per clock.
- Registered digits and sign drive the 7-segment / OLED numeric readout of the cursor coordinate.
- Uses a start/busy/done handshake so the display driver can request a refresh at any rate.

Parameters:
- WIDTH, 12, magnitude width in bits; also the number of SHIFT cycles.
- DIGITS, 4, BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH-1; elaboration-time check fails otherwise.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request conversion; sampled only in IDLE
- real_coord  input  WIDTH  unsigned magnitude
- sign  input  1  1 = negative
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle pulse when outputs are updated
- bcd  output  4*DIGITS  digit i at bits [4i+3:4i]; digit 0 is the units digit
- neg  output  1  registered display sign
- blank  output  DIGITS  leading-zero blank mask (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, bcd=0, neg=0, blank=0, all scratch registers 0.
- Reset mid-conversion: aborts immediately. No done pulse. Outputs return to reset values.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: capture real_coord into the shift register, capture sign, clear the BCD scratch, set cnt=0, go to SHIFT.
  - With start=0: stay in IDLE.
- SHIFT:
  - Each edge: every scratch digit >=5 gets +3; then {scratch, shift} shifts left by 1; cnt++.
  - On the edge where cnt==WIDTH-1 (the WIDTH-th shift): go to DONE.
- DONE:
  - Next edge: bcd <= scratch; neg <= captured sign AND (captured magnitude != 0), so "-0" never appears.
  - Same edge: blank is updated, done <= 1, state goes to IDLE.
- done: high for exactly one cycle. Outputs hold their values until the next DONE.
- Latency: start sampled at edge k → done high during the cycle after edge k+WIDTH+1 (k+13 for default parameters).
- busy: high from edge k to edge k+WIDTH+1, i.e. 13 cycles for default parameters.
- start while busy (SHIFT or DONE): ignored, not queued. Earliest re-accept is the edge after done rises.
- Input stability: real_coord and sign only need to be stable at the sampling edge; later changes do not affect the result.
- Width rules:
  - cnt is $clog2(WIDTH) bits.
  - Add-3 operates per 4-bit digit with no carry between digits.
  - The maximum input (2^WIDTH-1) never overflows DIGITS.

Optional Feature:
- Macro: COORD_BCD_LEADING_ZERO_BLANK_EN.
- When defined:
  - At the DONE edge, blank[i]=1 iff digit i and all higher digits are 0, for i>=1.
  - blank[0] is always 0, so a value of 0 shows as a single "0".
- When undefined:
  - blank is tied to all zeros and the blanking logic is not synthesised.
  - All other behaviour is identical.

Decomposition:
- Shared package coord_pkg:
  - COORD_W=12 and BCD_DIGITS=4 constants.
  - FSM state typedef {IDLE, SHIFT, DONE}.
  - Digit typedef logic[3:0].
- One natural sub-module: bcd_add3, a combinational per-digit "if >=5 then +3" cell, instantiated DIGITS times in a generate loop.

Test Plan:
- real_coord=4095, sign=0, start pulse at edge k → done at k+13; bcd=16'h4095, neg=0; busy high exactly 13 cycles.
- real_coord=0, sign=1 → bcd=16'h0000, neg=0 (no negative zero); with macro, blank=4'b1110.
- real_coord=1234, sign=1 → bcd=16'h1234, neg=1. Changing real_coord to 999 at edge k+3 does not affect the result.
- Conversion of 57 in progress; start with 800 asserted at k+5 → ignored; result 16'h0057, one done pulse only. New start at k+14 converts 800 → 16'h0800.
- rst_n low at edge k+6 mid-conversion → busy, done, bcd, neg all 0 immediately; no done pulse follows. Conversion after release works normally.
- Macro defined, real_coord=100 → blank=4'b1000. real_coord=7 → blank=4'b1110. Macro undefined → blank=0 for both.
